// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction, inserts bubbles on
// flush or load-use hazard, and forwards EX/MEM or MEM/WB results onto the ALU operands.
module id_ex_stage #(
    parameter int          DW     = 32,
    parameter int          RW     = 5,
    parameter logic [5:0]  NOP_OP = 6'd0
) (
    input  logic          clk,
    input  logic          reset,
    // id_valid qualifies every id_* field; when stall_id is high the upstream stage
    // holds the same instruction and re-presents it on the following cycle.
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [4:0]    id_aluctl,
    input  logic          id_sign,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_dst,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic          id_srca_sh,
    input  logic          id_srcb_imm,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_regwrite,
    input  logic          ex_flush,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_dst,
    input  logic [DW-1:0] exmem_data,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_dst,
    input  logic [DW-1:0] memwb_data,
    output logic          stall_id,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [4:0]    alu_ctl,
    output logic [5:0]    ex_opcode,
    output logic          ex_sign,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dst,
    output logic          ex_valid,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_regwrite
);

    logic          valid_q, valid_d;
    logic [5:0]    opcode_q, opcode_d;
    logic [4:0]    aluctl_q, aluctl_d;
    logic          sign_q, sign_d;
    logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, dst_q, dst_d;
    logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [4:0]    shamt_q, shamt_d;
    logic          srca_sh_q, srca_sh_d, srcb_imm_q, srcb_imm_d;
    logic          memread_q, memread_d, memwrite_q, memwrite_d, regwrite_q, regwrite_d;

    logic          haz;
    logic          bubble;
    logic [DW-1:0] fwd_rs, fwd_rt;

    assign haz = valid_q & memread_q & (dst_q != '0) & id_valid
               & ((dst_q == id_rs) | (dst_q == id_rt));
    assign stall_id = haz & ~ex_flush;
    assign bubble   = ex_flush | haz | ~id_valid;

    always_comb begin
        valid_d    = 1'b0;
        opcode_d   = NOP_OP;
        aluctl_d   = '0;
        sign_d     = 1'b0;
        rs_d       = '0;
        rt_d       = '0;
        dst_d      = '0;
        rs_data_d  = '0;
        rt_data_d  = '0;
        imm_d      = '0;
        shamt_d    = '0;
        srca_sh_d  = 1'b0;
        srcb_imm_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        regwrite_d = 1'b0;
        if (!bubble) begin
            valid_d    = 1'b1;
            opcode_d   = id_opcode;
            aluctl_d   = id_aluctl;
            sign_d     = id_sign;
            rs_d       = id_rs;
            rt_d       = id_rt;
            dst_d      = id_dst;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            shamt_d    = id_shamt;
            srca_sh_d  = id_srca_sh;
            srcb_imm_d = id_srcb_imm;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
            regwrite_d = id_regwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            opcode_q   <= '0;
            aluctl_q   <= '0;
            sign_q     <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            dst_q      <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            srca_sh_q  <= 1'b0;
            srcb_imm_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            opcode_q   <= opcode_d;
            aluctl_q   <= aluctl_d;
            sign_q     <= sign_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            dst_q      <= dst_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            srca_sh_q  <= srca_sh_d;
            srcb_imm_q <= srcb_imm_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            regwrite_q <= regwrite_d;
        end
    end

    // EX/MEM is the younger result, so it wins when both stages write the same register.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_regwrite && exmem_dst != '0 && exmem_dst == rs_q)
            fwd_rs = exmem_data;
        else if (memwb_regwrite && memwb_dst != '0 && memwb_dst == rs_q)
            fwd_rs = memwb_data;
        fwd_rt = rt_data_q;
        if (exmem_regwrite && exmem_dst != '0 && exmem_dst == rt_q)
            fwd_rt = exmem_data;
        else if (memwb_regwrite && memwb_dst != '0 && memwb_dst == rt_q)
            fwd_rt = memwb_data;
    end

    assign alu_in1       = srca_sh_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
    assign alu_in2       = srcb_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_ctl       = aluctl_q;
    assign ex_opcode     = opcode_q;
    assign ex_sign       = sign_q;
    assign ex_dst        = dst_q;
    assign ex_valid      = valid_q;
    assign ex_memread    = memread_q;
    assign ex_memwrite   = memwrite_q;
    assign ex_regwrite   = regwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a driver pushes expected outputs from an instruction-level
// reference model into a queue; a negedge monitor pops and compares them.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [4:0]  aluctl;
        logic        sign;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        srca_sh;
        logic        srcb_imm;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
    } instr_t;

    typedef struct packed {
        logic        ex_we;
        logic [4:0]  ex_dst;
        logic [31:0] ex_data;
        logic        wb_we;
        logic [4:0]  wb_dst;
        logic [31:0] wb_data;
    } fwd_t;

    typedef struct packed {
        logic        stall;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  ctl;
        logic [5:0]  op;
        logic        sign;
        logic [31:0] store;
        logic [4:0]  dst;
        logic        valid;
        logic        mr;
        logic        mw;
        logic        rw;
    } exp_t;

    logic        clk;
    logic        reset;
    instr_t      id;
    fwd_t        fw;
    logic        ex_flush;
    logic        stall_id;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [4:0]  alu_ctl, ex_dst;
    logic [5:0]  ex_opcode;
    logic        ex_sign, ex_valid, ex_memread, ex_memwrite, ex_regwrite;

    exp_t   exp_q[$];
    instr_t cur_ex, nxt_ex;
    exp_t   last_exp;
    int     total = 0;
    int     bad = 0;
    bit     done = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id.valid), .id_opcode(id.opcode), .id_aluctl(id.aluctl), .id_sign(id.sign),
        .id_rs(id.rs), .id_rt(id.rt), .id_dst(id.dst),
        .id_rs_data(id.rs_data), .id_rt_data(id.rt_data), .id_imm(id.imm),
        .id_shamt(id.shamt), .id_srca_sh(id.srca_sh), .id_srcb_imm(id.srcb_imm),
        .id_memread(id.memread), .id_memwrite(id.memwrite), .id_regwrite(id.regwrite),
        .ex_flush(ex_flush),
        .exmem_regwrite(fw.ex_we), .exmem_dst(fw.ex_dst), .exmem_data(fw.ex_data),
        .memwb_regwrite(fw.wb_we), .memwb_dst(fw.wb_dst), .memwb_data(fw.wb_data),
        .stall_id(stall_id), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl),
        .ex_opcode(ex_opcode), .ex_sign(ex_sign), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regval,
                                            input fwd_t f);
        if (idx == 0) return regval;
        if (f.ex_we && f.ex_dst == idx) return f.ex_data;
        if (f.wb_we && f.wb_dst == idx) return f.wb_data;
        return regval;
    endfunction

    function automatic logic load_use(input instr_t ex, input instr_t nxt);
        return ex.valid && ex.memread && ex.dst != 0 && nxt.valid &&
               (ex.dst == nxt.rs || ex.dst == nxt.rt);
    endfunction

    function automatic exp_t predict(input instr_t ex, input instr_t nxt, input logic flush,
                                     input fwd_t f);
        exp_t e;
        logic [31:0] rt_val;
        rt_val  = operand(ex.rt, ex.rt_data, f);
        e.stall = load_use(ex, nxt) && !flush;
        e.in1   = ex.srca_sh ? {27'd0, ex.shamt} : operand(ex.rs, ex.rs_data, f);
        e.in2   = ex.srcb_imm ? ex.imm : rt_val;
        e.store = rt_val;
        e.ctl   = ex.aluctl;
        e.op    = ex.opcode;
        e.sign  = ex.sign;
        e.dst   = ex.dst;
        e.valid = ex.valid;
        e.mr    = ex.memread;
        e.mw    = ex.memwrite;
        e.rw    = ex.regwrite;
        return e;
    endfunction

    // driver tasks
    task automatic drive(input instr_t i, input fwd_t f, input logic flush, input logic rst);
        id       = i;
        fw       = f;
        ex_flush = flush;
        reset    = rst;
        last_exp = predict(cur_ex, i, flush, f);
        exp_q.push_back(last_exp);
        if (rst || flush || load_use(cur_ex, i) || !i.valid) nxt_ex = '0;
        else nxt_ex = i;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cur_ex = nxt_ex;
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = ($urandom_range(0, 9) < 8);
        i.opcode   = 6'($urandom);
        i.aluctl   = 5'($urandom);
        i.sign     = 1'($urandom);
        i.rs       = 5'($urandom_range(0, 7));
        i.rt       = 5'($urandom_range(0, 7));
        i.dst      = 5'($urandom_range(0, 7));
        i.rs_data  = $urandom;
        i.rt_data  = $urandom;
        i.imm      = $urandom;
        i.shamt    = 5'($urandom);
        i.srca_sh  = ($urandom_range(0, 4) == 0);
        i.srcb_imm = ($urandom_range(0, 9) < 3);
        i.memread  = ($urandom_range(0, 9) < 3);
        i.memwrite = ($urandom_range(0, 9) < 2);
        i.regwrite = 1'($urandom);
        return i;
    endfunction

    function automatic fwd_t rand_fwd();
        fwd_t f;
        f.ex_we   = 1'($urandom);
        f.ex_dst  = 5'($urandom_range(0, 7));
        f.ex_data = $urandom;
        f.wb_we   = 1'($urandom);
        f.wb_dst  = 5'($urandom_range(0, 7));
        f.wb_data = $urandom;
        return f;
    endfunction

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall_id", 32'(stall_id), 32'(e.stall));
                check("alu_in1", alu_in1, e.in1);
                check("alu_in2", alu_in2, e.in2);
                check("alu_ctl", 32'(alu_ctl), 32'(e.ctl));
                check("ex_opcode", 32'(ex_opcode), 32'(e.op));
                check("ex_sign", 32'(ex_sign), 32'(e.sign));
                check("ex_store_data", ex_store_data, e.store);
                check("ex_dst", 32'(ex_dst), 32'(e.dst));
                check("ex_valid", 32'(ex_valid), 32'(e.valid));
                check("ex_memread", 32'(ex_memread), 32'(e.mr));
                check("ex_memwrite", 32'(ex_memwrite), 32'(e.mw));
                check("ex_regwrite", 32'(ex_regwrite), 32'(e.rw));
            end
        end
    end

    initial begin
        instr_t i, held;
        fwd_t   nf;
        nf       = '0;
        id       = '0;
        fw       = '0;
        ex_flush = 1'b0;
        reset    = 1'b1;
        cur_ex   = '0;
        nxt_ex   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        cur_ex = '0;

        // reset state
        drive('0, nf, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_valid", 32'(ex_valid), 32'd0);
        check("reset_stall", 32'(stall_id), 32'd0);
        check("reset_in1", alu_in1, 32'd0);
        advance();

        // EX/MEM wins over MEM/WB; r0 never forwarded
        i = '0; i.valid = 1; i.rs = 3; i.rs_data = 32'h99; i.regwrite = 1; i.dst = 7;
        drive(i, nf, 1'b0, 1'b0);
        advance();
        drive('0, '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22}, 1'b0, 1'b0);
        @(negedge clk);
        check("fwd_exmem_prio", alu_in1, 32'h11);
        advance();
        i = '0; i.valid = 1; i.rs = 0; i.rs_data = 32'h55;
        drive(i, nf, 1'b0, 1'b0);
        advance();
        drive('0, '{1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22}, 1'b0, 1'b0);
        @(negedge clk);
        check("fwd_r0_none", alu_in1, 32'h55);
        advance();

        // load-use: one stall, one bubble, then the held instruction with MEM/WB data
        i = '0; i.valid = 1; i.memread = 1; i.regwrite = 1; i.dst = 5; i.opcode = 6'h23;
        drive(i, nf, 1'b0, 1'b0);
        advance();
        held = '0; held.valid = 1; held.rs = 1; held.rt = 5; held.rt_data = 32'hdead;
        held.opcode = 6'h00; held.aluctl = 5'd2;
        drive(held, nf, 1'b0, 1'b0);
        @(negedge clk);
        check("lu_stall", 32'(stall_id), 32'd1);
        advance();
        drive(held, nf, 1'b0, 1'b0);
        @(negedge clk);
        check("lu_stall_once", 32'(stall_id), 32'd0);
        check("lu_bubble", 32'(ex_valid), 32'd0);
        advance();
        drive('0, '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'habcd}, 1'b0, 1'b0);
        @(negedge clk);
        check("lu_fwd_memwb", alu_in2, 32'habcd);
        check("lu_loaded", 32'(ex_valid), 32'd1);
        advance();

        // flush beats hazard
        i = '0; i.valid = 1; i.memread = 1; i.dst = 5;
        drive(i, nf, 1'b0, 1'b0);
        advance();
        i = '0; i.valid = 1; i.rs = 5; i.regwrite = 1; i.dst = 4;
        drive(i, nf, 1'b1, 1'b0);
        @(negedge clk);
        check("flush_no_stall", 32'(stall_id), 32'd0);
        advance();
        drive('0, nf, 1'b0, 1'b0);
        @(negedge clk);
        check("flush_bubble", 32'(ex_valid), 32'd0);
        advance();

        // shift by shamt
        i = '0; i.valid = 1; i.srca_sh = 1; i.shamt = 4; i.rt = 2; i.rt_data = 1;
        i.aluctl = 5'b10000; i.regwrite = 1; i.dst = 3;
        drive(i, nf, 1'b0, 1'b0);
        advance();
        drive('0, nf, 1'b0, 1'b0);
        @(negedge clk);
        check("sll_in1", alu_in1, 32'h4);
        check("sll_in2", alu_in2, 32'h1);
        check("sll_ctl", 32'(alu_ctl), 32'h10);
        advance();

        // immediate operand with forwarded store data
        i = '0; i.valid = 1; i.srcb_imm = 1; i.imm = 32'hffffffff; i.rt = 6; i.rt_data = 5;
        drive(i, nf, 1'b0, 1'b0);
        advance();
        drive('0, '{1'b1, 5'd6, 32'h777, 1'b0, 5'd0, 32'h0}, 1'b0, 1'b0);
        @(negedge clk);
        check("imm_in2", alu_in2, 32'hffffffff);
        check("imm_store", ex_store_data, 32'h777);
        advance();

        // reset mid-stream with a valid instruction presented
        i = rand_instr(); i.valid = 1;
        drive(i, nf, 1'b0, 1'b1);
        advance();
        drive('0, nf, 1'b0, 1'b0);
        @(negedge clk);
        check("midreset_valid", 32'(ex_valid), 32'd0);
        check("midreset_rw", 32'(ex_regwrite), 32'd0);
        check("midreset_ctl", 32'(alu_ctl), 32'd0);
        advance();

        // randomized stream; a stalled instruction is re-presented unchanged
        held = rand_instr();
        for (int n = 0; n < 400; n++) begin
            logic rst, fl;
            rst = ($urandom_range(0, 49) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            drive(held, rand_fwd(), fl, rst);
            if (!last_exp.stall || rst) held = rand_instr();
            advance();
        end
        reset = 1'b0;
        ex_flush = 1'b0;
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
